// File: rtl/rename_regfile_ckpt.sv
// Architectural register file with rename tags and branch checkpoints.
// Each register holds a committed value plus a busy/tag pair that names the ROB
// entry producing its next value. NCK checkpoint slots can snapshot and restore
// the busy/tag table. Values are never rolled back.
module rename_regfile_ckpt #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned ROB_W = 4,
    parameter int unsigned NRP   = 2,
    parameter int unsigned NCM   = 2,
    parameter int unsigned NCK   = 4,
    localparam int unsigned CK_W = (NCK > 1) ? $clog2(NCK) : 1,
    localparam int unsigned RA_W = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NRP*RA_W-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0]   rd_val,
    output logic [NRP-1:0]        rd_busy,
    output logic [NRP*ROB_W-1:0]  rd_tag,
    input  logic                  issue_valid,
    input  logic [RA_W-1:0]       issue_rd,
    input  logic [ROB_W-1:0]      issue_rob_pos,
    input  logic [NCM-1:0]        commit_valid,
    input  logic [NCM*RA_W-1:0]   commit_rd,
    input  logic [NCM*XLEN-1:0]   commit_val,
    input  logic [NCM*ROB_W-1:0]  commit_rob_pos,
    input  logic                  ckpt_save,
    input  logic [CK_W-1:0]       ckpt_save_id,
    input  logic                  ckpt_restore,
    input  logic [CK_W-1:0]       ckpt_restore_id,
    input  logic                  flush
);

    logic [XLEN-1:0]  val_q     [NREG];
    logic [NREG-1:0]  busy_q;
    logic [ROB_W-1:0] tag_q     [NREG];
    logic [NREG-1:0]  ck_busy_q [NCK];
    logic [ROB_W-1:0] ck_tag_q  [NCK][NREG];

    logic [XLEN-1:0]  val_d     [NREG];
    logic [NREG-1:0]  busy_d;
    logic [ROB_W-1:0] tag_d     [NREG];
    logic [NREG-1:0]  ck_busy_d [NCK];
    logic [ROB_W-1:0] ck_tag_d  [NCK][NREG];

    logic [RA_W-1:0]  r_addr;
    logic [XLEN-1:0]  r_val;
    logic             r_busy;
    logic [ROB_W-1:0] r_tag;
    logic [RA_W-1:0]  c_rd;
    logic [ROB_W-1:0] c_pos;

    // Combinational operand read with same-cycle commit bypass; higher commit port wins.
    always_comb begin
        rd_val  = '0;
        rd_busy = '0;
        rd_tag  = '0;
        r_addr  = '0;
        r_val   = '0;
        r_busy  = 1'b0;
        r_tag   = '0;
        for (int unsigned p = 0; p < NRP; p++) begin
            r_addr = rd_addr[p*RA_W +: RA_W];
            r_val  = '0;
            r_busy = 1'b0;
            r_tag  = '0;
            if (r_addr != '0) begin
                r_val  = val_q[r_addr];
                r_busy = busy_q[r_addr];
                r_tag  = tag_q[r_addr];
                for (int unsigned k = 0; k < NCM; k++) begin
                    if (commit_valid[k] && commit_rd[k*RA_W +: RA_W] == r_addr &&
                        busy_q[r_addr] && tag_q[r_addr] == commit_rob_pos[k*ROB_W +: ROB_W]) begin
                        r_busy = 1'b0;
                        r_val  = commit_val[k*XLEN +: XLEN];
                    end
                end
            end
            rd_val[p*XLEN +: XLEN]    = r_val;
            rd_busy[p]                = r_busy;
            rd_tag[p*ROB_W +: ROB_W]  = r_tag;
        end
    end

    // Next-state: value writes and checkpoint clears always apply; then flush > restore > commit/issue/save.
    always_comb begin
        val_d     = val_q;
        busy_d    = busy_q;
        tag_d     = tag_q;
        ck_busy_d = ck_busy_q;
        ck_tag_d  = ck_tag_q;
        c_rd      = '0;
        c_pos     = '0;
        for (int unsigned k = 0; k < NCM; k++) begin
            c_rd  = commit_rd[k*RA_W +: RA_W];
            c_pos = commit_rob_pos[k*ROB_W +: ROB_W];
            if (commit_valid[k] && c_rd != '0) begin
                val_d[c_rd] = commit_val[k*XLEN +: XLEN];
                for (int unsigned c = 0; c < NCK; c++) begin
                    if (ck_tag_q[c][c_rd] == c_pos)
                        ck_busy_d[c][c_rd] = 1'b0;
                end
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (ckpt_restore) begin
            // Restore takes the slot after this cycle's commit clears were applied to it.
            if (32'(ckpt_restore_id) < NCK) begin
                busy_d = ck_busy_d[ckpt_restore_id];
                tag_d  = ck_tag_q[ckpt_restore_id];
            end else begin
                busy_d = '0;
            end
        end else begin
            for (int unsigned k = 0; k < NCM; k++) begin
                c_rd  = commit_rd[k*RA_W +: RA_W];
                c_pos = commit_rob_pos[k*ROB_W +: ROB_W];
                if (commit_valid[k] && c_rd != '0 && tag_q[c_rd] == c_pos)
                    busy_d[c_rd] = 1'b0;
            end
            if (issue_valid && issue_rd != '0) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_rob_pos;
            end
            if (ckpt_save && 32'(ckpt_save_id) < NCK) begin
                ck_busy_d[ckpt_save_id] = busy_d;
                ck_tag_d[ckpt_save_id]  = tag_d;
            end
        end
    end

    // State registers: synchronous reset clears everything, rdy gates all updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int unsigned r = 0; r < NREG; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
            for (int unsigned c = 0; c < NCK; c++) begin
                ck_busy_q[c] <= '0;
                for (int unsigned r = 0; r < NREG; r++)
                    ck_tag_q[c][r] <= '0;
            end
        end else if (rdy) begin
            val_q     <= val_d;
            busy_q    <= busy_d;
            tag_q     <= tag_d;
            ck_busy_q <= ck_busy_d;
            ck_tag_q  <= ck_tag_d;
        end
    end

endmodule
